// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encoding.
package serial_subtractor_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell; purely combinational, registered by the caller.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a start/busy handshake and a one-cycle done pulse.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic             brw;
    logic             a_msb;
    logic             b_msb;
    logic             bout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             cell_d;
    logic             cell_bo;
    logic             load_c;
    logic             step_c;
    logic             last_c;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .diff (cell_d),
        .bout (cell_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step_c = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_c    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand shifters, borrow chain and result registers; results only move during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            brw    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load_c) begin
            cnt    <= '0;
            a_sh   <= a;
            b_sh   <= b;
            brw    <= bin;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (step_c) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            brw    <= cell_bo;
            diff_q <= {cell_d, diff_q[WIDTH-1:1]};
            if (last_c) begin
                bout_q <= cell_bo;
                // The bit computed now becomes diff's MSB.
                ovf_q  <= (a_msb != b_msb) && (cell_d != a_msb);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Handshake flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != S_IDLE);
            done_q <= (state_nxt == S_DONE);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign bout     = bout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and model-based bench for serial_subtractor at WIDTH=16 and WIDTH=4.
module tb_serial_subtractor;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        overflow;

    logic        s4_start;
    logic [3:0]  s4_a;
    logic [3:0]  s4_b;
    logic        s4_bin;
    logic        s4_busy;
    logic        s4_done;
    logic [3:0]  s4_diff;
    logic        s4_bout;
    logic        s4_overflow;

    int n_vec;
    int n_err;
    vec_t tbl[10];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .overflow(overflow)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .a(s4_a), .b(s4_b), .bin(s4_bin),
        .busy(s4_busy), .done(s4_done), .diff(s4_diff), .bout(s4_bout), .overflow(s4_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {overflow, borrow, diff} of x - y - c in w bits.
    function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
        int ux, uy, r, sx, sy, s, lim;
        logic [15:0] d;
        ux  = int'(x);
        uy  = int'(y);
        r   = ux - uy - int'(c);
        d   = 16'(r) & 16'((1 << w) - 1);
        lim = 1 << (w - 1);
        sx  = x[w-1] ? ux - (1 << w) : ux;
        sy  = y[w-1] ? uy - (1 << w) : uy;
        s   = sx - sy - int'(c);
        return {(s > lim - 1) || (s < -lim), r < 0, d};
    endfunction

    task automatic req16(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                         output logic [15:0] od, output logic ob, output logic oo, output int lat);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        od = diff; ob = bout; oo = overflow;
    endtask

    task automatic req4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                        output logic [3:0] od, output logic ob, output logic oo, output int lat);
        @(negedge clk);
        s4_start = 1'b1; s4_a = ia; s4_b = ib; s4_bin = ibin;
        @(posedge clk);
        @(negedge clk);
        s4_start = 1'b0;
        lat = 0;
        while (!s4_done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        od = s4_diff; ob = s4_bout; oo = s4_overflow;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [3:0]  rd4;
        logic        rb, ro;
        logic [15:0] ra, rbb;
        logic        rc;
        int          lat, k, seen;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_bin = 1'b0;

        tbl[0] = '{16'd5,    16'd3,    1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'd3,    16'd5,    1'b0, 16'hFFFE, 1'b1, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[5] = '{16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
        tbl[8] = '{16'h0001, 16'h8000, 1'b0, 16'h8001, 1'b1, 1'b1};
        tbl[9] = '{16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0};

        #12;
        chk("reset16", 32'({busy, done, bout, overflow, diff}), 32'h0);
        chk("reset4", 32'({s4_busy, s4_done, s4_bout, s4_overflow, s4_diff}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            req16(tbl[i].a, tbl[i].b, tbl[i].bin, rd, rb, ro, lat);
            chk($sformatf("v%0d_diff", i), 32'(rd), 32'(tbl[i].d));
            chk($sformatf("v%0d_bout", i), 32'(rb), 32'(tbl[i].bo));
            chk($sformatf("v%0d_ovf", i), 32'(ro), 32'(tbl[i].ov));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd16);
            @(negedge clk);
            chk($sformatf("v%0d_hold", i), 32'({done, busy, bout, overflow, diff}),
                32'({2'b00, tbl[i].bo, tbl[i].ov, tbl[i].d}));
        end

        // Start while busy (mid-RUN and in the done cycle) is dropped; next one is taken a cycle later.
        @(negedge clk);
        start = 1'b1; a = 16'd9; b = 16'd4; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; a = 16'd1; b = 16'd1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("coll_done", 32'(done), 32'd1);
        chk("coll_diff", 32'(diff), 32'h5);
        start = 1'b1; a = 16'd1; b = 16'd1;
        @(negedge clk);
        chk("coll_ignored", 32'({busy, done, diff}), 32'h5);
        @(negedge clk);
        chk("coll_accept", 32'({busy, diff}), 32'h10000);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("coll2_result", 32'({done, bout, overflow, diff}), 32'h40000);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("prerst_busy", 32'({busy, diff != 16'h0}), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({busy, done, bout, overflow, diff}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no_done_after_rst", 32'(seen), 32'd0);
        req16(16'd5, 16'd3, 1'b0, rd, rb, ro, lat);
        chk("after_rst", 32'({8'(lat), ro, rb, rd}), 32'({8'd16, 2'b00, 16'h0002}));

        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            rbb = 16'($urandom);
            rc  = 1'($urandom);
            req16(ra, rbb, rc, rd, rb, ro, lat);
            chk($sformatf("sweep16 a=%h b=%h bin=%b", ra, rbb, rc), 32'({8'(lat), ro, rb, rd}),
                32'({8'd16, model(16, ra, rbb, rc)}));
        end

        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom_range(15, 0));
            rbb = 16'($urandom_range(15, 0));
            rc  = 1'($urandom);
            req4(ra[3:0], rbb[3:0], rc, rd4, rb, ro, lat);
            chk($sformatf("sweep4 a=%h b=%h bin=%b", ra[3:0], rbb[3:0], rc),
                32'({8'(lat), ro, rb, 12'h000, rd4}), 32'({8'd4, model(4, ra, rbb, rc)}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
